pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 152 +++++++++++++++
 tb/tb_pc_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential increment, relative branch,
// absolute jump and an optional return-address stack for call/ret.
// Build option: define PC_UNIT_RAS_EN to include the return-address stack.
// Without it, call acts as jump, ret acts as increment, and the stack
// flags are tied off (ras_full=0, ras_empty=1, ras_err=0).
module pc_unit #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 1,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_value,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Modulo-2^WIDTH add of a two's-complement offset; wraps in both directions.
    function automatic logic [WIDTH-1:0] pc_offset(
        input logic [WIDTH-1:0]        base,
        input logic signed [WIDTH-1:0] off
    );
        pc_offset = base + $unsigned(off);
    endfunction

    logic [WIDTH-1:0]        pc_p0;
    logic [WIDTH-1:0]        pc_next;
    logic [WIDTH-1:0]        pc_inc;
    logic [WIDTH-1:0]        pc_br;
    logic signed [WIDTH-1:0] br_off_s;
    logic signed [WIDTH-1:0] step_s;

    assign br_off_s = branch_offset;
    assign step_s   = STEP_W;
    assign pc_inc   = pc_offset(pc_p0, step_s);
    assign pc_br    = pc_offset(pc_p0, br_off_s);

`ifdef PC_UNIT_RAS_EN
    localparam int               PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W:0]   ras_cnt;
    logic [PTR_W:0]   cnt_next;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;
    logic             push;
    logic             err_set;
    logic             err_q;

    // Count doubles as the write slot; the top entry sits one below it
    // (wraps to RAS_DEPTH-1 when the stack is full).
    assign wr_idx    = ras_cnt[PTR_W-1:0];
    assign top_idx   = wr_idx - IDX_ONE;
    assign ras_full  = (ras_cnt == CNT_FULL);
    assign ras_empty = (ras_cnt == '0);
    assign ras_err   = err_q;

    // Next-state selection in fixed priority: stall, ret, call, jump, branch, increment.
    always_comb begin
        pc_next  = pc_inc;
        cnt_next = ras_cnt;
        push     = 1'b0;
        err_set  = 1'b0;
        if (stall) begin
            pc_next = pc_p0;
        end else if (ret) begin
            if (!ras_empty) begin
                pc_next  = ras_mem[top_idx];
                cnt_next = ras_cnt - CNT_ONE;
            end else begin
                err_set = 1'b1;
            end
        end else if (call) begin
            pc_next = jump_target;
            if (!ras_full) begin
                push     = 1'b1;
                cnt_next = ras_cnt + CNT_ONE;
            end else begin
                err_set = 1'b1;
            end
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch) begin
            pc_next = pc_br;
        end
    end

    // Stack count and sticky overflow/underflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            ras_cnt <= cnt_next;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Stack storage holds data only; contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wr_idx] <= pc_inc;
        end
    end
`else
    // Next-state selection without a stack: call loads the target, ret steps.
    always_comb begin
        pc_next = pc_inc;
        if (stall) begin
            pc_next = pc_p0;
        end else if (ret) begin
            pc_next = pc_inc;
        end else if (call || jump) begin
            pc_next = jump_target;
        end else if (branch) begin
            pc_next = pc_br;
        end
    end

    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_err   = 1'b0;
`endif

    // Program counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_p0 <= RESET_VECTOR;
        end else begin
            pc_p0 <= pc_next;
        end
    end

    assign pc_value = pc_p0;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: scoreboard of expected pc/flags per cycle, driven
// by directed sequences plus randomized requests against a queue-based model.
module tb_pc_unit;

    localparam int         W     = 8;
    localparam logic [7:0] RV    = 8'h10;
    localparam int         STEP  = 1;
    localparam int         DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
    localparam bit HAS_RAS = 1'b1;
`else
    localparam bit HAS_RAS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         stall, jump, branch, call, ret;
    logic [W-1:0] jump_target, branch_offset;
    logic [W-1:0] pc_value;
    logic         ras_full, ras_empty, ras_err;

    pc_unit #(
        .WIDTH(W), .RESET_VECTOR(RV), .STEP(STEP), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump),
        .jump_target(jump_target), .branch(branch),
        .branch_offset(branch_offset), .call(call), .ret(ret),
        .pc_value(pc_value), .ras_full(ras_full), .ras_empty(ras_empty),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic [2:0] flags;   // {full, empty, err}
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   seq_id   = 0;

    // Reference model state: program counter, stack as a queue, sticky error.
    int   m_pc;
    int   m_stk[$];
    bit   m_err;

    task automatic chk(input string nm, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", nm, id, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = int'(RV);
        m_stk.delete();
        m_err = 1'b0;
    endtask

    // Apply one cycle of requests and queue the state expected after the next edge.
    task automatic drive(input bit st, input bit jp, input logic [7:0] jt,
                         input bit br, input logic [7:0] bo,
                         input bit cl, input bit rt);
        exp_t e;
        stall = st; jump = jp; jump_target = jt; branch = br;
        branch_offset = bo; call = cl; ret = rt;
        if (st) begin
        end else if (rt) begin
            if (HAS_RAS && m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_pc = (m_pc + STEP) % 256;
                if (HAS_RAS) m_err = 1'b1;
            end
        end else if (cl) begin
            if (HAS_RAS) begin
                if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + STEP) % 256);
                else m_err = 1'b1;
            end
            m_pc = int'(jt);
        end else if (jp) begin
            m_pc = int'(jt);
        end else if (br) begin
            m_pc = (m_pc + int'(bo)) % 256;
        end else begin
            m_pc = (m_pc + STEP) % 256;
        end
        seq_id++;
        e.pc    = 8'(m_pc);
        e.flags = {HAS_RAS && (m_stk.size() == DEPTH),
                   !HAS_RAS || (m_stk.size() == 0), m_err};
        e.id    = seq_id;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit st, input bit jp, input logic [7:0] jt,
                       input bit br, input logic [7:0] bo,
                       input bit cl, input bit rt);
        @(negedge clk);
        drive(st, jp, jt, br, bo, cl, rt);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_pc"}, seq_id, int'(pc_value), int'(RV));
        chk({nm, "_flags"}, seq_id, int'({ras_full, ras_empty, ras_err}), 3'b010);
    endtask

    // Monitor: the DUT presents a new state after every edge; pop and compare.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", e.id, int'(pc_value), int'(e.pc));
            chk("flags", e.id, int'({ras_full, ras_empty, ras_err}), int'(e.flags));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        stall = 0; jump = 0; branch = 0; call = 0; ret = 0;
        jump_target = '0; branch_offset = '0;
        model_reset();
        #12;
        check_reset_state("reset");

        // Reset release then idle stepping from the reset vector.
        release_reset();
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0);

        // Forward branch wrapping past the top, then a backward branch.
        cyc(0, 1, 8'hFE, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 1, 8'h05, 0, 0);
        cyc(0, 0, 8'h00, 1, 8'hFC, 0, 0);

        // Call then return.
        cyc(0, 1, 8'h20, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h80, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 1);

        // Five nested calls into a four-deep stack, then four returns.
        cyc(0, 1, 8'h30, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'(8'h50 + 8'(i * 16)), 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 0, 8'h00, 0, 1);

        // Stall dominates jump and call; then ret outranks call, call outranks jump.
        cyc(0, 0, 8'h60, 0, 8'h00, 1, 0);
        cyc(1, 1, 8'h99, 0, 8'h00, 1, 0);
        cyc(1, 1, 8'h99, 0, 8'h00, 1, 0);
        cyc(0, 1, 8'h99, 1, 8'h07, 1, 1);
        cyc(0, 1, 8'hA0, 1, 8'h07, 1, 0);
        cyc(0, 1, 8'hB0, 1, 8'h07, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 1);

        // Return on an empty stack, then asynchronous reset mid-cycle.
        cyc(0, 1, 8'h40, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        release_reset();

        // Randomized request mix.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 8'($urandom),
                $urandom_range(0, 2) == 0, 8'($urandom),
                $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end
        @(negedge clk);
        stall = 0; jump = 0; branch = 0; call = 0; ret = 0;

        // Let the monitor drain any outstanding expectations.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
